// File: rtl/wave_gen.sv
// Multi-mode modulation source (triangle, ramp up, ramp down, square) with
// programmable bounds, step and tick prescaler; settings reload only at cycle boundaries.
module wave_gen #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_in,
    input  logic [1:0]          mode_in,
    input  logic [WIDTH-1:0]    low_in,
    input  logic [WIDTH-1:0]    high_in,
    input  logic [WIDTH-1:0]    step_in,
    input  logic [PS_WIDTH-1:0] period_in,
    output logic [WIDTH-1:0]    mod_out,
    output logic                dir_out,
    output logic                cycle_out
);

    localparam logic [1:0] MODE_TRI  = 2'd0;
    localparam logic [1:0] MODE_UP   = 2'd1;
    localparam logic [1:0] MODE_DOWN = 2'd2;
    localparam logic [1:0] MODE_SQ   = 2'd3;

    localparam logic [WIDTH-1:0]    ONE_W  = WIDTH'(1);
    localparam logic [PS_WIDTH-1:0] ONE_PS = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] ps_cnt;
    logic [PS_WIDTH-1:0] div_q;
    logic [WIDTH-1:0]    low_q;
    logic [WIDTH-1:0]    high_q;
    logic [WIDTH-1:0]    step_q;
    logic [1:0]          mode_q;
    logic                start_q;
    logic [WIDTH-1:0]    sq_cnt;

    logic              tick;
    logic              boundary;
    logic [WIDTH-1:0]  step_eff;
    logic [WIDTH:0]    up_sum;
    logic [WIDTH:0]    low_sum;
    logic [WIDTH-1:0]  up_val;
    logic [WIDTH-1:0]  down_val;
    logic              at_floor;
    logic              half_done;
    logic [WIDTH-1:0]  entry_val;
    logic              entry_dir;
    logic [WIDTH-1:0]  mod_d;
    logic              dir_d;
    logic [WIDTH-1:0]  sq_d;

    assign tick      = enable_in && (ps_cnt == div_q);
    assign step_eff  = (step_q == '0) ? ONE_W : step_q;
    // Sums carry one extra bit so a step past either bound clamps instead of wrapping.
    assign up_sum    = {1'b0, mod_out} + {1'b0, step_eff};
    assign low_sum   = {1'b0, low_q} + {1'b0, step_eff};
    assign up_val    = (up_sum > {1'b0, high_q}) ? high_q : up_sum[WIDTH-1:0];
    assign at_floor  = ({1'b0, mod_out} <= low_sum);
    assign down_val  = at_floor ? low_q : (mod_out - step_eff);
    assign half_done = (sq_cnt == (step_eff - ONE_W));

    always_comb begin
        boundary = 1'b0;
        if (start_q || (low_q >= high_q)) begin
            boundary = 1'b1;
        end else begin
            case (mode_q)
                MODE_TRI:  boundary = dir_out && at_floor;
                MODE_UP:   boundary = (mod_out == high_q);
                MODE_DOWN: boundary = (mod_out == low_q);
                default:   boundary = dir_out && half_done;
            endcase
        end
    end

    // The first sample of a new cycle is taken from the values being loaded, so a
    // mode or bound change takes effect on the very boundary that loads it.
    always_comb begin
        entry_val = low_in;
        entry_dir = 1'b0;
        if (!start_q && (low_in < high_in)) begin
            case (mode_in)
                MODE_DOWN: begin
                    entry_val = high_in;
                    entry_dir = 1'b1;
                end
                MODE_SQ:   entry_val = high_in;
                default:   entry_val = low_in;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mod_d = mod_out;
        dir_d = dir_out;
        sq_d  = sq_cnt;
        if (boundary) begin
            mod_d = entry_val;
            dir_d = entry_dir;
            sq_d  = '0;
        end else if (mod_out < low_q) begin
            mod_d = low_q;
        end else if (mod_out > high_q) begin
            mod_d = high_q;
        end else begin
            case (mode_q)
                MODE_TRI: begin
                    if (!dir_out) begin
                        mod_d = up_val;
                        dir_d = (up_val == high_q);
                    end else begin
                        mod_d = mod_out - step_eff;
                    end
                end
                MODE_UP: begin
                    mod_d = up_val;
                    dir_d = 1'b0;
                end
                MODE_DOWN: begin
                    mod_d = down_val;
                    dir_d = 1'b1;
                end
                default: begin
                    // Only the end of the high half lands here; the low half ends at a boundary.
                    if (half_done) begin
                        mod_d = low_q;
                        dir_d = 1'b1;
                        sq_d  = '0;
                    end else begin
                        mod_d = dir_out ? low_q : high_q;
                        sq_d  = sq_cnt + ONE_W;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt    <= '0;
            div_q     <= '0;
            low_q     <= '0;
            high_q    <= '0;
            step_q    <= '0;
            mode_q    <= MODE_TRI;
            start_q   <= 1'b1;
            sq_cnt    <= '0;
            mod_out   <= '0;
            dir_out   <= 1'b0;
            cycle_out <= 1'b0;
        end else begin
            cycle_out <= tick && boundary;
            if (!enable_in) begin
                ps_cnt <= '0;
            end else if (tick) begin
                ps_cnt  <= '0;
                mod_out <= mod_d;
                dir_out <= dir_d;
                sq_cnt  <= sq_d;
                if (boundary) begin
                    low_q   <= low_in;
                    high_q  <= high_in;
                    step_q  <= step_in;
                    div_q   <= period_in;
                    mode_q  <= mode_in;
                    start_q <= 1'b0;
                end
            end else begin
                ps_cnt <= ps_cnt + ONE_PS;
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen: a per-cycle sample-list model predicts outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_wave_gen;

    typedef struct packed {
        logic [7:0] mod;
        logic       dir;
        logic       cyc;
    } exp_t;

    typedef struct {
        int val;
        bit dir;
    } sample_t;

    logic        clk;
    logic        rst_n;
    logic        enable_in;
    logic [1:0]  mode_in;
    logic [7:0]  low_in;
    logic [7:0]  high_in;
    logic [7:0]  step_in;
    logic [15:0] period_in;
    logic [7:0]  mod_out;
    logic        dir_out;
    logic        cycle_out;

    int errors = 0;
    int checks = 0;

    exp_t    sb_q[$];
    sample_t wave_q[$];
    exp_t    cur;
    int      m_cnt;
    int      m_div;
    bit      m_start;

    wave_gen #(.WIDTH(8), .PS_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable_in (enable_in),
        .mode_in   (mode_in),
        .low_in    (low_in),
        .high_in   (high_in),
        .step_in   (step_in),
        .period_in (period_in),
        .mod_out   (mod_out),
        .dir_out   (dir_out),
        .cycle_out (cycle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got mod=%0d dir=%0b cyc=%0b, expected mod=%0d dir=%0b cyc=%0b",
                     name, $time, got.mod, got.dir, got.cyc, exp.mod, exp.dir, exp.cyc);
        end
    endtask

    function automatic void push_s(int v, bit d);
        sample_t s;
        s.val = v;
        s.dir = d;
        wave_q.push_back(s);
    endfunction

    // Full list of samples one wave cycle will emit, from the inputs being loaded.
    function automatic void build_cycle(bit start);
        int lo = int'(low_in);
        int hi = int'(high_in);
        int s  = (step_in == 0) ? 1 : int'(step_in);
        int v;
        wave_q.delete();
        if (lo >= hi) begin
            push_s(lo, 0);
            return;
        end
        if (start && mode_in == 2'd2) begin
            push_s(lo, 0);
            return;
        end
        if (start && mode_in == 2'd3) begin
            push_s(lo, 0);
            for (int i = 1; i < s; i++) push_s(hi, 0);
            for (int i = 0; i < s; i++) push_s(lo, 1);
            return;
        end
        case (mode_in)
            2'd0: begin
                v = lo;
                push_s(v, 0);
                while (v < hi) begin
                    v = (v + s > hi) ? hi : v + s;
                    push_s(v, v == hi);
                end
                while (v - s > lo) begin
                    v = v - s;
                    push_s(v, 1);
                end
            end
            2'd1: begin
                v = lo;
                push_s(v, 0);
                while (v < hi) begin
                    v = (v + s > hi) ? hi : v + s;
                    push_s(v, 0);
                end
            end
            2'd2: begin
                v = hi;
                push_s(v, 1);
                while (v > lo) begin
                    v = (v - s < lo) ? lo : v - s;
                    push_s(v, 1);
                end
            end
            default: begin
                for (int i = 0; i < s; i++) push_s(hi, 0);
                for (int i = 0; i < s; i++) push_s(lo, 1);
            end
        endcase
    endfunction

    function automatic void model_step();
        sample_t s;
        if (!rst_n) begin
            m_cnt   = 0;
            m_div   = 0;
            m_start = 1;
            wave_q.delete();
            cur = '0;
        end else if (!enable_in) begin
            m_cnt   = 0;
            cur.cyc = 1'b0;
        end else if (m_cnt == m_div) begin
            m_cnt = 0;
            if (m_start || wave_q.size() == 0) begin
                build_cycle(m_start);
                m_start = 0;
                m_div   = int'(period_in);
                cur.cyc = 1'b1;
            end else begin
                cur.cyc = 1'b0;
            end
            s = wave_q.pop_front();
            cur.mod = 8'(s.val);
            cur.dir = s.dir;
        end else begin
            m_cnt++;
            cur.cyc = 1'b0;
        end
        sb_q.push_back(cur);
    endfunction

    // One clock: predict the effect of the current inputs, then let the DUT clock.
    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input int lo, input int hi,
                           input int st, input int per);
        mode_in   = m;
        low_in    = 8'(lo);
        high_in   = 8'(hi);
        step_in   = 8'(st);
        period_in = 16'(per);
    endtask

    // Monitor: every negedge compares the DUT outputs with the oldest prediction.
    initial begin
        exp_t exp;
        exp_t got;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                got = '{mod: mod_out, dir: dir_out, cyc: cycle_out};
                check("wave", got, exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        enable_in = 1'b0;
        set_cfg(2'd0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        cycle(2);

        rst_n     = 1'b1;
        enable_in = 1'b1;
        set_cfg(2'd0, 0, 3, 1, 0);
        cycle(14);

        set_cfg(2'd0, 2, 9, 3, 0);
        cycle(9);
        set_cfg(2'd0, 2, 5, 3, 0);
        cycle(12);

        set_cfg(2'd1, 10, 13, 1, 2);
        cycle(30);

        set_cfg(2'd3, 1, 200, 2, 0);
        cycle(18);

        enable_in = 1'b0;
        cycle(5);
        enable_in = 1'b1;
        cycle(7);

        set_cfg(2'd2, 20, 60, 7, 1);
        cycle(25);
        rst_n = 1'b0;
        cycle(2);
        rst_n = 1'b1;
        set_cfg(2'd0, 7, 7, 3, 0);
        cycle(8);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int lo = int'($urandom_range(0, 255));
                int hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                      : lo + int'($urandom_range(0, 40));
                if (hi > 255) hi = 255;
                set_cfg(2'($urandom_range(0, 3)), lo, hi, int'($urandom_range(0, 12)),
                        int'($urandom_range(0, 3)));
            end
            enable_in = ($urandom_range(0, 9) != 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            cycle(1);
        end
        rst_n = 1'b1;
        cycle(3);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
